// File: rtl/mem_block_mover.sv
// Word-granular COPY/FILL bus initiator for the data memory port.
// Port outputs are registered from the next-state decode, so they are glitch-free.
module mem_block_mover #(
  parameter int CNT_W  = 10,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_fill,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       fill_value,
  output logic              busy,
  output logic              done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_FILL, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [31:0]       buf_q, buf_d, fill_q, fill_d, wdata_q, wdata_d;
  logic              busy_q, busy_d, done_q, done_d, rd_q, rd_d, wr_q, wr_d;

  // Byte-offset bits are dropped on purpose; transfers are word aligned.
  logic unused_lsbs;
  assign unused_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;

    case (state_q)
      S_IDLE: if (start) begin
        src_d  = {src_addr[ADDR_W-1:2], 2'b00};
        dst_d  = {dst_addr[ADDR_W-1:2], 2'b00};
        rem_d  = word_count;
        fill_d = fill_value;
        if (word_count == '0) state_d = S_DONE;
        else if (op_fill)     state_d = S_FILL;
        else                  state_d = S_READ;
      end
      S_READ: begin
        buf_d   = read_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        src_d   = src_q + ADDR_W'(4);
        dst_d   = dst_q + ADDR_W'(4);
        rem_d   = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_READ;
      end
      S_FILL: begin
        dst_d   = dst_q + ADDR_W'(4);
        rem_d   = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_FILL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Drive the port for the state being entered; IDLE/DONE stay quiet.
    case (state_d)
      S_READ: begin
        busy_d = 1'b1;
        rd_d   = 1'b1;
        addr_d = src_d;
      end
      S_WRITE: begin
        busy_d  = 1'b1;
        wr_d    = 1'b1;
        addr_d  = dst_d;
        wdata_d = buf_d;
      end
      S_FILL: begin
        busy_d  = 1'b1;
        wr_d    = 1'b1;
        addr_d  = dst_d;
        wdata_d = fill_d;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_read   = rd_q;
  assign mem_write  = wr_q;
  assign address    = addr_q;
  assign write_data = wdata_q;

endmodule
